opnd_fifo: RTL
==============

OPND_FIFO -- requirements
Module: opnd_fifo

Purpose: 8-bit operand buffer sitting directly upstream of the datapath inverter stage; decouples the operand source from the inverter input with valid/ready handshakes on both sides.

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; the inverter operand width.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear of all entries.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_data  input  WIDTH  operand from the source.
REQ-008 in_ready  output  1  FIFO can accept an entry this cycle.
REQ-009 out_valid  output  1  out_data holds a valid operand for the inverter.
REQ-010 out_data  output  WIDTH  head entry, fed to the inverter input.
REQ-011 out_ready  input  1  downstream consumes the head entry.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-013 drop_err  output  1  sticky flag: a push was lost to flush.

Function
REQ-014 push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the rising clk edge.
REQ-015 in_ready SHALL be (count != DEPTH). It is combinational from state only, with no dependence on out_ready, so there is no full-bypass path.
REQ-016 out_valid SHALL be (count != 0). It is combinational from state only, with no dependence on in_valid, so there is no empty-bypass path.
REQ-017 On push, in_data SHALL be written at wr_ptr, and wr_ptr SHALL advance modulo DEPTH.
REQ-018 On pop, rd_ptr SHALL advance modulo DEPTH.
REQ-019 out_data SHALL be mem[rd_ptr] (show-ahead) when count != 0, else all zeros.
REQ-020 Latency: an entry pushed at edge N SHALL be visible on out_data/out_valid after edge N, i.e. one cycle when the FIFO was empty.
REQ-021 count next value: +1 on push only; -1 on pop only; unchanged when both or neither occur.
REQ-022 Simultaneous push and pop at 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-024 Entries SHALL be delivered in exact push order across pointer wrap-around.
REQ-025 flush=1 at an edge SHALL set count=0, wr_ptr=0 and rd_ptr=0, and SHALL override any push or pop in that cycle; a popped entry in that cycle is still considered consumed.
REQ-026 If flush=1 and push=1 in the same cycle, the entry SHALL be discarded and drop_err SHALL set to 1.
REQ-027 drop_err SHALL clear only on reset.
REQ-028 Storage contents are not reset; only pointers, count and flags are reset.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force count=0, wr_ptr=rd_ptr=0, drop_err=0, out_valid=0, in_ready=1 and out_data=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; no partial push SHALL survive.
REQ-031 After rst_n deasserts, the first push SHALL be accepted at the first rising edge with in_valid=1.

Verification
REQ-032 Single operand: rst_n released, push 8'hA5 with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, count=1; hold 3 cycles -> out_data stays 8'hA5.
REQ-033 Fill and backpressure: push 8'h01..8'h04 with out_ready=0 -> count=4, in_ready=0; a fifth push of 8'h05 is not accepted; pop all four -> 01,02,03,04 in order, then out_valid=0, out_data=8'h00.
REQ-034 Wrap and concurrency: push and pop every cycle for 10 operands 8'h10..8'h19 -> count steady at 1, outputs in order, pointers wrap with no loss.
REQ-035 Flush collision: count=3, then flush=1 with in_valid=1 and in_data=8'hFF -> next cycle count=0, out_valid=0, drop_err=1; drop_err still 1 after 5 more cycles.
REQ-036 Async reset mid-stream: count=2, drop rst_n between edges -> outputs go to reset values before the next edge; after release, push 8'h3C -> out_data=8'h3C, count=1.

Source files
------------

// File: rtl/opnd_fifo.sv
// Operand buffer ahead of the datapath inverter: show-ahead FIFO with
// valid/ready handshakes on both sides, synchronous flush and a sticky drop flag.
module opnd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here depend only on stored state, never on the peer.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (push) begin
                drop_err <= 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
